// File: rtl/free_list_ctrl_pkg.sv
// Shared constants, state encoding and pointer helper for the physical-register free list.
package free_list_ctrl_pkg;

    localparam int N_WAY     = 2;
    localparam int NUM_PR    = 64;
    localparam int NUM_ARCH  = 32;
    localparam int TAG_W     = 6;
    localparam int FL_DEPTH  = NUM_PR - NUM_ARCH;
    localparam int INIT_FREE = NUM_PR - NUM_ARCH - 1;
    localparam int PTR_W     = $clog2(FL_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int LANE_W    = (N_WAY > 1) ? $clog2(N_WAY) : 1;

    localparam logic [TAG_W-1:0] NULL_TAG   = '0;
    localparam logic [CNT_W-1:0] FL_DEPTH_C = CNT_W'(FL_DEPTH);

    typedef enum logic {
        FL_NORMAL  = 1'b0,
        FL_RECOVER = 1'b1
    } fl_state_t;

    // Circular pointer advance; n never exceeds N_WAY so one fold is enough.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input logic [CNT_W-1:0] n);
        logic [CNT_W:0] s;
        s = {2'b00, p} + {1'b0, n};
        if (s >= {1'b0, FL_DEPTH_C}) begin
            s = s - {1'b0, FL_DEPTH_C};
        end
        return s[PTR_W-1:0];
    endfunction

endpackage

// File: rtl/fl_lane_grant.sv
// Lane-ordered grant: each requesting lane takes the next free tag while any remain.
module fl_lane_grant
    import free_list_ctrl_pkg::*;
(
    input  logic                         i_en,
    input  logic [N_WAY-1:0]             i_req,
    input  logic [CNT_W-1:0]             i_count,
    input  logic [N_WAY-1:0][TAG_W-1:0]  i_cand,
    output logic [N_WAY-1:0][TAG_W-1:0]  o_tag,
    output logic [N_WAY-1:0]             o_grant,
    output logic [CNT_W-1:0]             o_num
);

    logic [CNT_W-1:0] w_rank;

    // w_rank is the number of grants handed to lower lanes, i.e. the offset from head.
    always_comb begin
        w_rank  = '0;
        o_tag   = '0;
        o_grant = '0;
        for (int i = 0; i < N_WAY; i++) begin
            if (i_en && i_req[i] && (w_rank < i_count)) begin
                o_grant[i] = 1'b1;
                o_tag[i]   = i_cand[w_rank[LANE_W-1:0]];
                w_rank     = w_rank + CNT_W'(1);
            end
        end
    end

    assign o_num = w_rank;

endmodule

// File: rtl/free_list_ctrl.sv
// Physical tag free list: same-cycle grants to dispatch lanes, retire-time reclaim,
// and rollback to the committed head/count through a one-cycle RECOVER state.
module free_list_ctrl
    import free_list_ctrl_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_WAY-1:0]             alloc_req,
    output logic [N_WAY-1:0][TAG_W-1:0]  pr_freelist,
    output logic [N_WAY-1:0]             alloc_grant,
    output logic [CNT_W-1:0]             free_count,
    input  logic [N_WAY-1:0]             retire_valid,
    input  logic [N_WAY-1:0][TAG_W-1:0]  retire_told,
    input  logic                         rollback,
    output logic                         recovering
);

    logic [TAG_W-1:0] r_fl [FL_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W-1:0] r_commit_head;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_commit_count;
    fl_state_t        r_state;

    fl_state_t                   w_state_next;
    logic [N_WAY-1:0][TAG_W-1:0] w_cand;
    logic                        w_grant_en;
    logic [CNT_W-1:0]            w_grant_num;
    logic [N_WAY-1:0]            w_push_en;
    logic [N_WAY-1:0][PTR_W-1:0] w_push_idx;
    logic [CNT_W-1:0]            w_push_num;
    logic [CNT_W-1:0]            w_retire_num;
    logic [PTR_W-1:0]            w_head_next;
    logic [PTR_W-1:0]            w_tail_next;
    logic [PTR_W-1:0]            w_commit_head_next;
    logic [CNT_W:0]              w_count_wide;
    logic [CNT_W:0]              w_commit_wide;

    // The first N_WAY entries from head are the only tags a cycle can hand out.
    generate
        for (genvar gi = 0; gi < N_WAY; gi++) begin : gen_cand
            assign w_cand[gi] = r_fl[ptr_add(r_head, CNT_W'(gi))];
        end
    endgenerate

    assign w_grant_en = (r_state == FL_NORMAL) && !rollback && !reset;

    fl_lane_grant u_grant (
        .i_en    (w_grant_en),
        .i_req   (alloc_req),
        .i_count (r_count),
        .i_cand  (w_cand),
        .o_tag   (pr_freelist),
        .o_grant (alloc_grant),
        .o_num   (w_grant_num)
    );

    // Retiring lanes with a null Told advance the commit head but push nothing.
    always_comb begin
        w_push_en    = '0;
        w_push_idx   = '0;
        w_push_num   = '0;
        w_retire_num = '0;
        for (int i = 0; i < N_WAY; i++) begin
            w_push_idx[i] = ptr_add(r_tail, w_push_num);
            if (retire_valid[i] && (retire_told[i] != NULL_TAG)) begin
                w_push_en[i] = 1'b1;
                w_push_num   = w_push_num + CNT_W'(1);
            end
            if (retire_valid[i]) begin
                w_retire_num = w_retire_num + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_tail_next        = ptr_add(r_tail, w_push_num);
        w_commit_head_next = ptr_add(r_commit_head, w_retire_num);
        w_commit_wide      = {1'b0, r_commit_count} - {1'b0, w_retire_num}
                           + {1'b0, w_push_num};
        w_head_next        = ptr_add(r_head, w_grant_num);
        w_count_wide       = {1'b0, r_count} - {1'b0, w_grant_num}
                           + {1'b0, w_push_num};
        w_state_next       = FL_NORMAL;
        if (rollback) begin
            // Restore includes this cycle's retires; their pushes still land at tail.
            w_head_next  = w_commit_head_next;
            w_count_wide = w_commit_wide;
            w_state_next = FL_RECOVER;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < FL_DEPTH; k++) begin
                r_fl[k] <= (k < INIT_FREE) ? TAG_W'(NUM_ARCH + 1 + k) : NULL_TAG;
            end
            r_head         <= '0;
            r_commit_head  <= '0;
            r_tail         <= PTR_W'(INIT_FREE);
            r_count        <= CNT_W'(INIT_FREE);
            r_commit_count <= CNT_W'(INIT_FREE);
            r_state        <= FL_NORMAL;
        end else begin
            for (int i = 0; i < N_WAY; i++) begin
                if (w_push_en[i]) begin
                    r_fl[w_push_idx[i]] <= retire_told[i];
                end
            end
            r_head         <= w_head_next;
            r_tail         <= w_tail_next;
            r_commit_head  <= w_commit_head_next;
            r_count        <= w_count_wide[CNT_W-1:0];
            r_commit_count <= w_commit_wide[CNT_W-1:0];
            r_state        <= w_state_next;
        end
    end

    // More pushes than free slots would overwrite live entries.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (w_count_wide <= {1'b0, FL_DEPTH_C});
            assert (w_commit_wide <= {1'b0, FL_DEPTH_C});
        end
    end

    assign free_count = r_count;
    assign recovering = (r_state == FL_RECOVER);

endmodule

// File: tb/tb_free_list_ctrl.sv
// Directed vector bench for free_list_ctrl: table of single-cycle vectors plus
// hand sequences for drain/empty refill, wrap-around and mid-run reset.
module tb_free_list_ctrl;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      alloc_req = '0;
    logic [1:0][5:0] pr_freelist;
    logic [1:0]      alloc_grant;
    logic [5:0]      free_count;
    logic [1:0]      retire_valid = '0;
    logic [1:0][5:0] retire_told = '0;
    logic            rollback = 1'b0;
    logic            recovering;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    free_list_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .alloc_req    (alloc_req),
        .pr_freelist  (pr_freelist),
        .alloc_grant  (alloc_grant),
        .free_count   (free_count),
        .retire_valid (retire_valid),
        .retire_told  (retire_told),
        .rollback     (rollback),
        .recovering   (recovering)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [1:0] rv;
        logic [5:0] t0;
        logic [5:0] t1;
        logic       rb;
        logic       ct;
        logic       cc;
        logic       cr;
        logic [1:0] eg;
        logic [5:0] ep0;
        logic [5:0] ep1;
        logic [5:0] ecnt;
        logic       erec;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s txn %0d actual %0d required %0d", nm, txn, act, exp);
        end
    endtask

    // Drive one cycle of inputs at negedge, then check outputs 1 time unit later.
    task automatic step(input logic rst, input logic [1:0] req, input logic [1:0] rv,
                        input logic [5:0] t0, input logic [5:0] t1, input logic rb,
                        input logic ct, input logic cc, input logic cr,
                        input logic [1:0] eg, input logic [5:0] ep0, input logic [5:0] ep1,
                        input logic [5:0] ecnt, input logic erec);
        @(negedge clock);
        reset          = rst;
        alloc_req      = req;
        retire_valid   = rv;
        retire_told[0] = t0;
        retire_told[1] = t1;
        rollback       = rb;
        #1;
        txn++;
        $display("txn %0d rst=%b req=%b rv=%b told=%0d,%0d rb=%b -> grant=%b tags=%0d,%0d free=%0d rec=%b",
                 txn, rst, req, rv, t0, t1, rb, alloc_grant, pr_freelist[0], pr_freelist[1],
                 free_count, recovering);
        chk("alloc_grant", 32'(alloc_grant), 32'(eg));
        if (ct) begin
            chk("pr_freelist0", 32'(pr_freelist[0]), 32'(ep0));
            chk("pr_freelist1", 32'(pr_freelist[1]), 32'(ep1));
        end
        if (cc) chk("free_count", 32'(free_count), 32'(ecnt));
        if (cr) chk("recovering", 32'(recovering), 32'(erec));
    endtask

    initial begin
        //            rst   req    rv     t0  t1  rb   ct   cc   cr   eg     p0  p1  cnt rec
        vecs[0]  = '{1'b1, 2'b11, 2'b00, 0,  0,  1'b0,1'b1,1'b0,1'b0,2'b00, 0,  0,  0,  1'b0};
        vecs[1]  = '{1'b0, 2'b11, 2'b00, 0,  0,  1'b0,1'b1,1'b1,1'b1,2'b11, 33, 34, 31, 1'b0};
        vecs[2]  = '{1'b0, 2'b00, 2'b00, 0,  0,  1'b0,1'b1,1'b1,1'b1,2'b00, 0,  0,  29, 1'b0};
        vecs[3]  = '{1'b1, 2'b00, 2'b00, 0,  0,  1'b0,1'b1,1'b0,1'b0,2'b00, 0,  0,  0,  1'b0};
        vecs[4]  = '{1'b0, 2'b10, 2'b00, 0,  0,  1'b0,1'b1,1'b1,1'b1,2'b10, 0,  33, 31, 1'b0};
        vecs[5]  = '{1'b0, 2'b00, 2'b00, 0,  0,  1'b0,1'b1,1'b1,1'b1,2'b00, 0,  0,  30, 1'b0};
        vecs[6]  = '{1'b1, 2'b00, 2'b00, 0,  0,  1'b0,1'b1,1'b0,1'b0,2'b00, 0,  0,  0,  1'b0};
        vecs[7]  = '{1'b0, 2'b11, 2'b00, 0,  0,  1'b0,1'b1,1'b1,1'b1,2'b11, 33, 34, 31, 1'b0};
        vecs[8]  = '{1'b0, 2'b11, 2'b00, 0,  0,  1'b0,1'b1,1'b1,1'b1,2'b11, 35, 36, 29, 1'b0};
        vecs[9]  = '{1'b0, 2'b11, 2'b01, 1,  0,  1'b1,1'b1,1'b1,1'b1,2'b00, 0,  0,  27, 1'b0};
        vecs[10] = '{1'b0, 2'b11, 2'b00, 0,  0,  1'b0,1'b1,1'b1,1'b1,2'b00, 0,  0,  31, 1'b1};
        vecs[11] = '{1'b0, 2'b01, 2'b00, 0,  0,  1'b0,1'b1,1'b1,1'b1,2'b01, 34, 0,  31, 1'b0};
        vecs[12] = '{1'b0, 2'b11, 2'b00, 0,  0,  1'b1,1'b1,1'b1,1'b1,2'b00, 0,  0,  30, 1'b0};
        vecs[13] = '{1'b0, 2'b11, 2'b00, 0,  0,  1'b1,1'b1,1'b1,1'b1,2'b00, 0,  0,  31, 1'b1};
        vecs[14] = '{1'b0, 2'b11, 2'b00, 0,  0,  1'b0,1'b1,1'b1,1'b1,2'b00, 0,  0,  31, 1'b1};
        vecs[15] = '{1'b0, 2'b01, 2'b00, 0,  0,  1'b0,1'b1,1'b1,1'b1,2'b01, 34, 0,  31, 1'b0};

        for (int v = 0; v < 16; v++) begin
            step(vecs[v].rst, vecs[v].req, vecs[v].rv, vecs[v].t0, vecs[v].t1, vecs[v].rb,
                 vecs[v].ct, vecs[v].cc, vecs[v].cr, vecs[v].eg, vecs[v].ep0, vecs[v].ep1,
                 vecs[v].ecnt, vecs[v].erec);
        end

        // Drain 31 -> 1, take the last tag with a partial grant, then refill from empty.
        step(1, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        for (int j = 0; j < 15; j++) begin
            step(0, 2'b11, 2'b00, 0, 0, 0, 1, 1, 1, 2'b11,
                 6'(33 + 2 * j), 6'(34 + 2 * j), 6'(31 - 2 * j), 0);
        end
        step(0, 2'b11, 2'b00, 0, 0, 0, 1, 1, 1, 2'b01, 63, 0, 1, 0);
        step(0, 2'b11, 2'b11, 5, 7, 0, 1, 1, 1, 2'b00, 0, 0, 0, 0);
        step(0, 2'b11, 2'b00, 0, 0, 0, 1, 1, 1, 2'b11, 5, 7, 2, 0);
        step(0, 2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 2'b00, 0, 0, 0, 0);

        // Steady alloc+retire until head and tail have both wrapped, drain to 10, reset.
        step(1, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        for (int j = 0; j < 20; j++) begin
            step(0, 2'b11, 2'b11, 1, 2, 0, (j < 15), 1, 1, 2'b11,
                 6'(33 + 2 * j), 6'(34 + 2 * j), 31, 0);
        end
        for (int j = 0; j < 10; j++) begin
            step(0, 2'b11, 2'b00, 0, 0, 0, 0, 1, 1, 2'b11, 0, 0, 6'(31 - 2 * j), 0);
        end
        step(0, 2'b01, 2'b00, 0, 0, 0, 0, 1, 1, 2'b01, 0, 0, 11, 0);
        step(0, 2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 2'b00, 0, 0, 10, 0);
        step(1, 2'b01, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        step(0, 2'b01, 2'b00, 0, 0, 0, 1, 1, 1, 2'b01, 33, 0, 31, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
